// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter width; a 1-bit adder still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used by the serial adder datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, WIDTH steps per operation.
// Optional two's-complement overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output state_t           state_o
);

  // Handshake: start is a level request honoured only on an IDLE edge (ignored
  // otherwise, never queued); done is a one-cycle pulse, after which sum/cout
  // stay stable until the next accepted start.

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_cout;
  logic             last_step;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last_step = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Sum bits enter at the MSB so that after WIDTH steps bit 0 is at bit 0.
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = fa_s;
        a_d              = a_q >> 1;
        b_d              = b_q >> 1;
        carry_d          = fa_cout;
        cnt_d            = cnt_q + CW'(1);
        if (last_step) begin
          state_d = DONE;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ fa_cout;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy    = (state_q == SHIFT);
  assign done    = (state_q == DONE);
  assign sum     = sum_q;
  assign cout    = carry_q;
  assign state_o = state_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 and WIDTH=1 instances against an arithmetic model.
module tb_serial_adder;
  import serial_adder_pkg::*;

  logic       clk;
  logic       rst;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  state_t     state8;

  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;
  state_t     state1;

`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf1;
`endif

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [9:0] exp_q[$];
  logic [9:0] e_m;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk     (clk),
    .rst     (rst),
    .start   (start8),
    .a       (a8),
    .b       (b8),
    .cin     (cin8),
    .busy    (busy8),
    .done    (done8),
    .sum     (sum8),
    .cout    (cout8),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf     (ovf8),
`endif
    .state_o (state8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .start   (start1),
    .a       (a1),
    .b       (b1),
    .cin     (cin1),
    .busy    (busy1),
    .done    (done1),
    .sum     (sum1),
    .cout    (cout1),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf     (ovf1),
`endif
    .state_o (state1)
  );

  // Clock and timeout
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: {ovf, cout, sum} from integer addition and sign rules
  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int unsigned t;
    logic [7:0]  s;
    logic        v;
    t = int'(a) + int'(b) + int'(c);
    s = t[7:0];
    v = (a[7] == b[7]) && (s[7] != a[7]);
    return {v, t[8], s};
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding operation
  always @(posedge clk) begin
    #1;
    if (done8) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e_m = exp_q.pop_front();
        check("sum", sum8, e_m[7:0]);
        check("cout", cout8, e_m[8]);
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", ovf8, e_m[9]);
`endif
      end
    end
  end

  // Driver: one operation on the 8-bit DUT; optional start spam while busy
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit spam);
    logic [9:0] e;
    int ndone, lat;
    e = model8(a, b, c);
    exp_q.push_back(e);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(posedge clk); #1;
    check("busy_on_accept", busy8, 1);
    ndone = 0; lat = 0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (spam && k <= 9) begin
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      if (done8) begin
        ndone++;
        lat = k;
      end
    end
    check("done_count", ndone, 1);
    check("done_latency", lat, 8);
    check("sum_held", sum8, e[7:0]);
    check("cout_held", cout8, e[8]);
    check("idle_after", state8, IDLE);
  endtask

  task automatic do_op1(input logic a, input logic b, input logic c);
    logic [1:0] e;
    int ndone, lat;
    e = 2'(int'(a) + int'(b) + int'(c));
    @(negedge clk);
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    @(posedge clk); #1;
    check("w1_busy", busy1, 1);
    ndone = 0; lat = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      @(posedge clk); #1;
      if (done1) begin
        ndone++;
        lat = k;
        check("w1_sum", sum1, e[0]);
        check("w1_cout", cout1, e[1]);
`ifdef SERIAL_ADDER_OVF_EN
        check("w1_ovf", ovf1, c ^ e[1]);
`endif
      end
    end
    check("w1_done_count", ndone, 1);
    check("w1_latency", lat, 1);
  endtask

  task automatic reset_mid_op();
    int ndone;
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_state", state8, IDLE);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_sum", sum8, 0);
    check("rst_cout", cout8, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done8) ndone++;
    end
    check("rst_no_done", ndone, 0);
  endtask

  // Start held high: one operation every WIDTH+2 cycles
  task automatic throughput8(input int n_ops);
    logic [7:0] ta, tb_v;
    logic       tc;
    int edge_n, ndone, last;
    ta = 8'($urandom_range(0, 255)); tb_v = 8'($urandom_range(0, 255)); tc = 1'($urandom_range(0, 1));
    exp_q.push_back(model8(ta, tb_v, tc));
    @(negedge clk);
    a8 = ta; b8 = tb_v; cin8 = tc; start8 = 1'b1;
    edge_n = 0; ndone = 0; last = 0;
    while (ndone < n_ops && edge_n < 200) begin
      @(posedge clk); #1;
      edge_n++;
      if (done8) begin
        ndone++;
        if (ndone == 1) check("thr_first_latency", edge_n - 1, 8);
        else            check("thr_gap", edge_n - last, 10);
        last = edge_n;
        @(negedge clk);
        if (ndone < n_ops) begin
          ta = 8'($urandom_range(0, 255)); tb_v = 8'($urandom_range(0, 255)); tc = 1'($urandom_range(0, 1));
          exp_q.push_back(model8(ta, tb_v, tc));
          a8 = ta; b8 = tb_v; cin8 = tc;
        end else begin
          start8 = 1'b0;
        end
      end
    end
    check("thr_ops", ndone, n_ops);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", state8, IDLE);
    check("reset_busy", busy8, 0);
    check("reset_done", done8, 0);
    check("reset_sum", sum8, 0);
    check("reset_cout", cout8, 0);
    check("reset_w1_sum", sum1, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check("reset_ovf", ovf8, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    do_op8(8'h00, 8'h00, 1'b0, 1'b0);
    do_op8(8'hFF, 8'h01, 1'b0, 1'b0);
    do_op8(8'h5A, 8'hA5, 1'b1, 1'b0);
    do_op8(8'h7F, 8'h01, 1'b0, 1'b0);
    do_op8(8'h80, 8'h80, 1'b0, 1'b0);
    do_op8(8'h12, 8'h34, 1'b0, 1'b1);

    reset_mid_op();
    do_op8(8'h12, 8'h34, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      do_op1(1'(i >> 2), 1'(i >> 1), 1'(i));
    end

    for (int i = 0; i < 30; i++) begin
      do_op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    throughput8(4);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 1..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin one addition; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  first operand, captured on the accepted start edge.
REQ-006 SHALL have port b  input  WIDTH  second operand, captured on the accepted start edge.
REQ-007 SHALL have port cin  input  1  carry-in, captured on the accepted start edge.
REQ-008 SHALL have port busy  output  1  high while the adder is in SHIFT.
REQ-009 SHALL have port done  output  1  single-cycle pulse marking a valid result.
REQ-010 SHALL have port sum  output  WIDTH  result of a+b+cin modulo 2^WIDTH.
REQ-011 SHALL have port cout  output  1  carry out of the MSB.

Function
REQ-012 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-013 SHALL, in IDLE with start=1, load a, b and cin into internal shift and carry registers, clear the bit counter, and move to SHIFT.
REQ-014 SHALL, on each SHIFT edge, pass the LSBs of a and b plus the carry register to one full-adder cell, shift s into the sum register from the MSB end, shift a and b right by one, update the carry register with cout, and increment the counter.
REQ-015 SHALL move from SHIFT to DONE on the edge at which the counter equals WIDTH-1, so that exactly WIDTH bit-steps occur.
REQ-016 SHALL hold done=1 for exactly the one cycle spent in DONE, which begins on the WIDTH-th rising edge after the start-sampling edge, and then return to IDLE.
REQ-017 SHALL present sum and cout as valid from the DONE cycle and hold them unchanged until the next accepted start.
REQ-018 SHALL ignore start in SHIFT and DONE: no reload and no queuing.
REQ-019 SHALL, with start held high continuously, accept one operation every WIDTH+2 cycles.
REQ-020 SHALL, for WIDTH=1, pass through SHIFT for one cycle and produce results identical to a single full adder.

Reset
REQ-021 SHALL, on any edge with rst=1, go to IDLE and force busy=0, done=0, sum=0, cout=0, counter=0 and the carry register to 0.
REQ-022 SHALL give rst priority over start and abort any operation in progress without producing a done pulse.

Configuration
REQ-023 SHALL, when the macro SERIAL_ADDER_OVF_EN is defined, add an output port ovf (1 bit) equal to the two's-complement overflow, i.e. the carry into the MSB XOR cout. ovf SHALL be registered with sum, held with sum, and reset to 0.
REQ-024 SHALL, when SERIAL_ADDER_OVF_EN is undefined, have no ovf port and no associated logic.

Structure
REQ-025 SHALL import a shared package serial_adder_pkg that holds the FSM state typedef (IDLE, SHIFT, DONE) and the default-width constant.
REQ-026 SHALL instantiate the existing full_adder module (ports a, b, cin, s, cout) as its only sub-module, with exactly one instance.

Verification
REQ-027 SHALL verify zero addition: WIDTH=8, a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0, with done pulsing on the 8th edge after start.
REQ-028 SHALL verify carry propagation: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Also a=0x5A, b=0xA5, cin=1 -> sum=0x00, cout=1.
REQ-029 SHALL verify that start is ignored while busy: a second start with a=0x01, b=0x01, issued during SHIFT, leaves the first result unchanged (0x12+0x34 -> 0x46, cout=0) and produces exactly one done pulse.
REQ-030 SHALL verify reset mid-operation: rst asserted on bit-step 4 -> the next cycle shows IDLE, busy=0, sum=0, and no done; a fresh start then completes correctly.
REQ-031 SHALL verify the WIDTH=1 case exhaustively: all 8 combinations of a, b and cin produce sum and cout matching the full-adder truth table.
REQ-032 SHALL verify overflow with SERIAL_ADDER_OVF_EN defined: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; and a=0xFF, b=0x01 -> ovf=0.
